// File: rtl/sampstream_arb_if.sv
// ============================================================================
// sampstream_arb_if : sample-stream sources and merged output bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface sampstream_arb_if #(
  parameter int NUM_CH = 4
);
  logic [32*NUM_CH-1:0] ch_data;
  logic [8*NUM_CH-1:0]  ch_count;
  logic [NUM_CH-1:0]    ch_avail;
  logic [NUM_CH-1:0]    ch_enable;
  logic [NUM_CH-1:0]    ch_pull;
  logic [31:0]          out_data;
  logic                 out_avail;
  logic                 out_pull;
  logic                 out_last;
  logic [2:0]           out_chan;

  modport master (
    input  ch_data, ch_count, ch_avail, ch_enable, out_pull,
    output ch_pull, out_data, out_avail, out_last, out_chan
  );

  modport slave (
    output ch_data, ch_count, ch_avail, ch_enable, out_pull,
    input  ch_pull, out_data, out_avail, out_last, out_chan
  );
endinterface

`default_nettype wire

// File: rtl/sampstream_arb.sv
// ============================================================================
// sampstream_arb : round-robin burst arbiter merging NUM_CH sample streams
// Optional header beat per burst: define SAMPSTREAM_ARB_HEADER_EN. Rev 1.0
// ============================================================================
`default_nettype none

module sampstream_arb #(
  parameter int NUM_CH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  sampstream_arb_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
`ifdef SAMPSTREAM_ARB_HEADER_EN
  localparam logic [1:0] S_HEADER = 2'd1;
`endif
  localparam logic [1:0] S_BURST  = 2'd2;
  localparam logic [2:0] C_LAST_RST = 3'(NUM_CH - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] last_grant_q, last_grant_d;
  logic [2:0] chan_q, chan_d;
  logic [7:0] remaining_q, remaining_d;

  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_sel;
  logic [2:0]        w_grant;
  logic              w_found;
  logic              w_gavail;
  logic [31:0]       w_gdata;
  logic              w_xfer;
  logic [31:0]       w_out_data;
  logic              w_out_avail;
  logic              w_out_last;
  int                w_idx;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign w_elig[i] = bus.ch_enable[i] & bus.ch_avail[i] &
                         (bus.ch_count[8*i +: 8] != 8'd0);
      assign w_sel[i]  = (chan_q == 3'(i));
      assign bus.ch_pull[i] = (state_q == S_BURST) & w_sel[i] &
                              bus.out_pull & bus.ch_avail[i];
    end
  endgenerate

  assign w_found  = |w_elig;
  assign w_gavail = |(bus.ch_avail & w_sel);
  assign w_gdata  = bus.ch_data[32*chan_q +: 32];
  assign w_xfer   = (state_q == S_BURST) & w_gavail & bus.out_pull;

  // Scan farthest-first so the nearest eligible index after last_grant wins.
  always_comb begin
    w_grant = '0;
    w_idx   = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = (int'(last_grant_q) + k) % NUM_CH;
      if (w_elig[w_idx]) w_grant = 3'(w_idx);
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    chan_d       = chan_q;
    remaining_d  = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          chan_d      = w_grant;
          remaining_d = bus.ch_count[8*w_grant +: 8];
`ifdef SAMPSTREAM_ARB_HEADER_EN
          state_d     = S_HEADER;
`else
          state_d     = S_BURST;
`endif
        end
      end
`ifdef SAMPSTREAM_ARB_HEADER_EN
      S_HEADER: begin
        if (bus.out_pull) state_d = S_BURST;
      end
`endif
      S_BURST: begin
        if (w_xfer) begin
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            state_d      = S_IDLE;
            last_grant_d = chan_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= C_LAST_RST;
      chan_q       <= 3'd0;
      remaining_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      chan_q       <= chan_d;
      remaining_q  <= remaining_d;
    end
  end

  always_comb begin
    w_out_data  = '0;
    w_out_avail = 1'b0;
    w_out_last  = 1'b0;
    case (state_q)
`ifdef SAMPSTREAM_ARB_HEADER_EN
      S_HEADER: begin
        w_out_avail = 1'b1;
        w_out_data  = {8'h5A, 5'd0, chan_q, 8'd0, remaining_q};
      end
`endif
      S_BURST: begin
        w_out_data  = w_gdata;
        w_out_avail = w_gavail;
        w_out_last  = (remaining_q == 8'd1);
      end
      default: ;
    endcase
  end

  assign bus.out_data  = w_out_data;
  assign bus.out_avail = w_out_avail;
  assign bus.out_last  = w_out_last;
  assign bus.out_chan  = chan_q;

endmodule

`default_nettype wire

// File: doc/sampstream_arb.md
SAMPSTREAM_ARB -- requirements
Module: sampstream_arb

Interface
REQ-001 Parameter NUM_CH, default 4, number of sample-stream sources (legal 2..8).
REQ-002 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port ch_data  input  32*NUM_CH  per-channel stream word; channel i at bits [32*i+31:32*i].
REQ-005 Port ch_count  input  8*NUM_CH  per-channel count of words immediately available; channel i at bits [8*i+7:8*i].
REQ-006 Port ch_avail  input  NUM_CH  per-channel word-valid.
REQ-007 Port ch_enable  input  NUM_CH  per-channel arbitration enable.
REQ-008 Port ch_pull  output  NUM_CH  per-channel word-accept strobe.
REQ-009 Port out_data  output  32  merged stream word.
REQ-010 Port out_avail  output  1  merged word valid.
REQ-011 Port out_pull  input  1  downstream accept.
REQ-012 Port out_last  output  1  marks final data word of a burst.
REQ-013 Port out_chan  output  3  channel index of the current burst.

Function
REQ-014 A transfer on any stream occurs in a cycle where avail and pull are both high; data is sampled in that cycle.
REQ-015 The block SHALL use states IDLE, HEADER, BURST.
REQ-016 IDLE: channel i is eligible if ch_enable[i] && ch_avail[i] && ch_count[i]!=0; out_avail=0, ch_pull=0.
REQ-017 IDLE with at least one eligible channel: at the next edge, grant the first eligible index searching upward from (last_grant+1) mod NUM_CH, latch grant into out_chan and ch_count[grant] into remaining (8 bit), then enter HEADER.
REQ-018 HEADER: out_avail=1, out_data={8'h5A,5'd0,out_chan,8'd0,remaining}, out_last=0, ch_pull=0; on out_pull enter BURST.
REQ-019 BURST: out_data=ch_data[grant], out_avail=ch_avail[grant], ch_pull[grant]=out_pull && ch_avail[grant] (combinational), all other ch_pull=0.
REQ-020 BURST: each transfer decrements remaining; out_last=1 when remaining==1; transfer with remaining==1 enters IDLE and sets last_grant=grant.
REQ-021 BURST with ch_avail[grant]=0 SHALL stall (no timeout, no abort); remaining unchanged.
REQ-022 Changes to ch_enable, ch_count or other channels' signals during HEADER/BURST SHALL NOT alter the latched grant or remaining.
REQ-023 No two ch_pull bits SHALL be high in the same cycle; ch_pull is never high outside BURST.
REQ-024 Minimum gap: one IDLE cycle between consecutive bursts (back-to-back bursts never merge).
REQ-025 out_chan holds its value from grant until the next grant.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, last_grant=NUM_CH-1 (channel 0 wins first), remaining=0, out_chan=0.
REQ-027 During and after reset, before any grant: out_avail=0, out_last=0, out_data=0, ch_pull=0.
REQ-028 Reset asserted mid-burst SHALL drop ch_pull and out_avail asynchronously; the partial burst is discarded with no completion.

Configuration
REQ-029 Macro SAMPSTREAM_ARB_HEADER_EN defined: HEADER state present exactly as REQ-017/018.
REQ-030 SAMPSTREAM_ARB_HEADER_EN undefined: HEADER state absent; IDLE grant enters BURST directly; out_chan and out_last are the only framing.

Verification
REQ-031 HEADER_EN, ch0 count=3, avail=1, out_pull=1 constant -> header 0x5A00_0003, then ch0 words 1,2,3, out_last on third, ch_pull[0] high exactly 3 cycles.
REQ-032 All 4 channels eligible, count=1 each, out_pull=1 -> grants in order 0,1,2,3,0; out_chan follows.
REQ-033 ch1 granted count=4, ch_avail[1] low for 5 cycles after second word -> stall, no ch_pull, then words 3,4, out_last on word 4.
REQ-034 ch2 count=0 with avail=1, ch_enable[3]=0 with count=5 -> neither granted; IDLE persists, out_avail=0.
REQ-035 rst_n pulsed low during ch0 burst word 2 of 5 -> ch_pull and out_avail low within the reset cycle; after release ch0 granted first again with freshly latched count.
REQ-036 Header disabled build, ch3 count=2 -> first beat is ch3 word 1 (no header), out_last on word 2.
